// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
//
// Controls a car-park entry/exit lane watched by two photo-sensors. The outer
// sensor (sens_a) and inner sensor (sens_b) are synchronised, then a direction
// FSM tracks a car breaking a, a+b, b, none (entry) or b, b+a, a, none (exit).
// A completed entry pulses inc, a completed exit pulses dec. An entry attempt
// on a full lot pulses reject. A sequence that stalls in one state for TIMEOUT
// cycles is aborted with a timeout pulse. After a reject or abort, the FSM waits
// for both beams to clear before accepting a new car.
//
// Parameters
//   CAPACITY  lot capacity in cars (1..15)
//   TIMEOUT   maximum cycles allowed in any single mid-sequence state
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   sens_a     outer beam broken (asynchronous)
//   sens_b     inner beam broken (asynchronous)
//   count      current occupancy from the external lot counter
//   inc        one-cycle pulse: one car entered
//   dec        one-cycle pulse: one car exited
//   full       count >= CAPACITY (combinational)
//   empty      count == 0 (combinational)
//   gate_open  entry barrier open (state EN1..EN3)
//   reject     one-cycle pulse: entry attempted while full
//   timeout    one-cycle pulse: stalled sequence aborted
//   state      current FSM state encoding, for debug
// -----------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int CAPACITY = 15,
    parameter int TIMEOUT  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic [3:0] count,
    output logic       inc,
    output logic       dec,
    output logic       full,
    output logic       empty,
    output logic       gate_open,
    output logic       reject,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN1      = 3'd1,
        EN2      = 3'd2,
        EN3      = 3'd3,
        EX1      = 3'd4,
        EX2      = 3'd5,
        EX3      = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    localparam int            DW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(TIMEOUT - 1);
    localparam logic [3:0]    CAP        = 4'(CAPACITY);

    // Two-flop synchronisers for the free-running sensor inputs
    logic a_meta_q, a_sync_q, b_meta_q, b_sync_q;
    logic [1:0] ab;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          reject_q, reject_d;
    logic          timeout_q, timeout_d;
    logic          gate_q, gate_d;
    logic          in_seq;

    assign ab    = {a_sync_q, b_sync_q};
    assign full  = (count >= CAP);
    assign empty = (count == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
        end else begin
            a_meta_q <= sens_a;
            a_sync_q <= a_meta_q;
            b_meta_q <= sens_b;
            b_sync_q <= b_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dwell_q   <= '0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
            gate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
            gate_q    <= gate_d;
        end
    end

    assign in_seq = (state_q != IDLE) && (state_q != WAIT_CLR);

    always_comb begin
        state_d   = state_q;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ab == 2'b10) begin
                    if (full) begin
                        state_d  = WAIT_CLR;
                        reject_d = 1'b1;
                    end else begin
                        state_d = EN1;
                    end
                end else if (ab == 2'b01) begin
                    // An exit from an empty lot is bogus: swallow it silently
                    state_d = empty ? WAIT_CLR : EX1;
                end
            end
            EN1: case (ab)
                2'b11:   state_d = EN2;
                2'b00:   state_d = IDLE;
                2'b01:   state_d = WAIT_CLR;
                default: state_d = state_q;
            endcase
            EN2: case (ab)
                2'b01:   state_d = EN3;
                2'b10:   state_d = EN1;
                2'b00:   state_d = IDLE;
                default: state_d = state_q;
            endcase
            EN3: case (ab)
                2'b00: begin
                    state_d = IDLE;
                    inc_d   = 1'b1;
                end
                2'b11:   state_d = EN2;
                2'b10:   state_d = WAIT_CLR;
                default: state_d = state_q;
            endcase
            EX1: case (ab)
                2'b11:   state_d = EX2;
                2'b00:   state_d = IDLE;
                2'b10:   state_d = WAIT_CLR;
                default: state_d = state_q;
            endcase
            EX2: case (ab)
                2'b10:   state_d = EX3;
                2'b01:   state_d = EX1;
                2'b00:   state_d = IDLE;
                default: state_d = state_q;
            endcase
            EX3: case (ab)
                2'b00: begin
                    state_d = IDLE;
                    dec_d   = 1'b1;
                end
                2'b11:   state_d = EX2;
                2'b01:   state_d = WAIT_CLR;
                default: state_d = state_q;
            endcase
            WAIT_CLR: begin
                if (ab == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The timeout only fires when no real transition is pending, so a
        // sensor move on the same edge always takes priority.
        if (in_seq && (state_d == state_q) && (dwell_q == DWELL_LAST)) begin
            state_d   = WAIT_CLR;
            timeout_d = 1'b1;
        end

        if ((state_d == state_q) && in_seq) begin
            dwell_d = dwell_q + 1'b1;
        end else begin
            dwell_d = '0;
        end

        gate_d = (state_d == EN1) || (state_d == EN2) || (state_d == EN3);
    end

    assign inc       = inc_q;
    assign dec       = dec_q;
    assign reject    = reject_q;
    assign timeout   = timeout_q;
    assign gate_open = gate_q;
    assign state     = state_q;

endmodule
